// File: rtl/cordic_pkg.sv
// Shared constants and fold-code encodings for the CORDIC front end and post-processor.
// Latency: none (package only).
// Backpressure: not applicable.
package cordic_pkg;

  // Word format: signed Q7.8 (1 sign bit, 7 integer bits, 8 fraction bits)
  localparam int CORDIC_INPUT_WIDTH      = 16;
  localparam int CORDIC_INPUT_INT_WIDTH  = 7;
  localparam int CORDIC_INPUT_FRAC_WIDTH = 8;
  localparam int CORDIC_FLIP_FLAG_WIDTH  = 2;
  localparam int CORDIC_FIFO_DEPTH       = 4;

  // Angle constants held at one bit wider than the word so the fold arithmetic cannot overflow
  localparam logic signed [16:0] DEG_90  = 17'sh05A00;
  localparam logic signed [16:0] DEG_180 = 17'sh0B400;

  // Fold codes; the post-processor uses these to undo the fold
  localparam logic [1:0] FLIP_NONE    = 2'b00;
  localparam logic [1:0] FLIP_ROT180  = 2'b01;
  localparam logic [1:0] FLIP_VEC_NEG = 2'b10;

endpackage

// File: rtl/cordic_prefold_fifo.sv
// Request buffer for cordic_prefold: synchronous FIFO with registered occupancy count.
// Latency: a pushed entry is visible at the head one cycle after the push edge.
// Backpressure: caller must only push when count < DEPTH and only pop when count != 0.
module cordic_prefold_fifo
  import cordic_pkg::*;
#(
  parameter int WIDTH = 3 * CORDIC_INPUT_WIDTH + 1,
  parameter int DEPTH = CORDIC_FIFO_DEPTH
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           i_push,
  input  logic [WIDTH-1:0]               i_push_dat,
  input  logic                           i_pop,
  output logic [WIDTH-1:0]               o_head_dat,
  output logic [$clog2(DEPTH+1)-1:0]     o_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  // Storage write; contents need no reset because count gates every read
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; reset discards all entries
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head_dat = r_mem[r_rd_ptr];
  assign o_count    = r_count;

endmodule

// File: rtl/cordic_prefold.sv
// Folds buffered requests into the CORDIC convergence range and issues one per enabled cycle.
// Latency: accepted at edge k into an empty FIFO with issue_en high -> valid_out after edge k+1.
// Backpressure: req_ready drops when the FIFO is full; CORDIC_PREFOLD_SAT_EN saturates -0x8000.
module cordic_prefold
  import cordic_pkg::*;
#(
  parameter int INPUT_WIDTH      = CORDIC_INPUT_WIDTH,
  parameter int INPUT_INT_WIDTH  = CORDIC_INPUT_INT_WIDTH,
  parameter int INPUT_FRAC_WIDTH = CORDIC_INPUT_FRAC_WIDTH,
  parameter int FLIP_FLAG_WIDTH  = CORDIC_FLIP_FLAG_WIDTH,
  parameter int FIFO_DEPTH       = CORDIC_FIFO_DEPTH
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic [INPUT_WIDTH-1:0]             req_degree,
  input  logic [INPUT_WIDTH-1:0]             req_x,
  input  logic [INPUT_WIDTH-1:0]             req_y,
  input  logic                               req_arctan_en,
  input  logic                               issue_en,
  output logic [INPUT_WIDTH-1:0]             degree_out,
  output logic [INPUT_WIDTH-1:0]             x_out,
  output logic [INPUT_WIDTH-1:0]             y_out,
  output logic [FLIP_FLAG_WIDTH-1:0]         flip_out,
  output logic                               arctan_en_out,
  output logic                               valid_out,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

  localparam int W  = INPUT_WIDTH;
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int DW = 3 * W + 1;

  localparam logic signed [W:0] L_POS_90  = (W+1)'(DEG_90);
  localparam logic signed [W:0] L_NEG_90  = -L_POS_90;
  localparam logic signed [W:0] L_DEG_180 = (W+1)'(DEG_180);

  // Reject configurations the fold and pointer arithmetic cannot handle
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("cordic_prefold: FIFO_DEPTH must be a power of two and at least 2");
  end
  if ((INPUT_INT_WIDTH + INPUT_FRAC_WIDTH + 1) != INPUT_WIDTH) begin : g_bad_format
    $error("cordic_prefold: integer + fraction + sign bits must equal INPUT_WIDTH");
  end
  if (FLIP_FLAG_WIDTH < 2) begin : g_bad_flip
    $error("cordic_prefold: FLIP_FLAG_WIDTH must hold the two-bit fold codes");
  end

  // Negation used by the vectoring fold; only the most negative word needs special care
  function automatic logic [W-1:0] neg_word(input logic [W-1:0] v);
    logic [W-1:0] res;
    res = -v;
`ifdef CORDIC_PREFOLD_SAT_EN
    if (v == {1'b1, {(W-1){1'b0}}}) begin
      res = {1'b0, {(W-1){1'b1}}};
    end
`endif
    return res;
  endfunction

  logic                       w_push;
  logic                       w_pop;
  logic [DW-1:0]              w_push_dat;
  logic [DW-1:0]              w_head_dat;
  logic [W-1:0]               w_head_deg;
  logic [W-1:0]               w_head_x;
  logic [W-1:0]               w_head_y;
  logic                       w_head_arc;
  logic signed [W:0]          w_theta;
  logic [W-1:0]               w_fold_deg;
  logic [W-1:0]               w_fold_x;
  logic [W-1:0]               w_fold_y;
  logic [FLIP_FLAG_WIDTH-1:0] w_fold_flip;

  // Ready comes from the registered count, so a same-cycle pop never opens a slot early
  assign req_ready  = !reset && (fifo_count < CW'(FIFO_DEPTH));
  assign w_push     = req_valid && req_ready;
  assign w_pop      = issue_en && (fifo_count != '0);
  assign w_push_dat = {req_degree, req_x, req_y, req_arctan_en};

  cordic_prefold_fifo #(
    .WIDTH (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_push),
    .i_push_dat (w_push_dat),
    .i_pop      (w_pop),
    .o_head_dat (w_head_dat),
    .o_count    (fifo_count)
  );

  assign w_head_deg = w_head_dat[3*W -: W];
  assign w_head_x   = w_head_dat[2*W -: W];
  assign w_head_y   = w_head_dat[W -: W];
  assign w_head_arc = w_head_dat[0];
  assign w_theta    = {w_head_deg[W-1], w_head_deg};

  // Fold the FIFO head into range: rotate by 180 for |angle| > 90, negate the vector for x < 0
  always_comb begin
    w_fold_deg  = w_head_deg;
    w_fold_x    = w_head_x;
    w_fold_y    = w_head_y;
    w_fold_flip = FLIP_FLAG_WIDTH'(FLIP_NONE);
    if (w_head_arc) begin
      w_fold_deg = '0;
      if (w_head_x[W-1]) begin
        w_fold_x    = neg_word(w_head_x);
        w_fold_y    = neg_word(w_head_y);
        w_fold_flip = FLIP_FLAG_WIDTH'(FLIP_VEC_NEG);
      end
    end else if (w_theta > L_POS_90) begin
      w_fold_deg  = W'(w_theta - L_DEG_180);
      w_fold_flip = FLIP_FLAG_WIDTH'(FLIP_ROT180);
    end else if (w_theta < L_NEG_90) begin
      w_fold_deg  = W'(w_theta + L_DEG_180);
      w_fold_flip = FLIP_FLAG_WIDTH'(FLIP_ROT180);
    end
  end

  // Output register: strobe on every pop, data held between issues
  always_ff @(posedge clk) begin
    if (reset) begin
      degree_out    <= '0;
      x_out         <= '0;
      y_out         <= '0;
      flip_out      <= '0;
      arctan_en_out <= 1'b0;
      valid_out     <= 1'b0;
    end else begin
      valid_out <= w_pop;
      if (w_pop) begin
        degree_out    <= w_fold_deg;
        x_out         <= w_fold_x;
        y_out         <= w_fold_y;
        flip_out      <= w_fold_flip;
        arctan_en_out <= w_head_arc;
      end
    end
  end

endmodule
